// File: rtl/karatsuba_mul_arbiter_pkg.sv
// karatsuba_mul_arbiter_pkg: shared defaults and width helper for the shared-multiplier arbiter
package karatsuba_mul_arbiter_pkg;
  localparam int N_DEF = 15;
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/karatsuba_mul_arbiter_karatsuba.sv
// Karatsuba_0: combinational one-level Karatsuba unsigned multiplier, N x N -> 2N
module Karatsuba_0 #(
  parameter int N = 15
) (
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [2*N-1:0] o_p
);
  localparam int L = (N + 1) / 2;
  localparam int W = 2 * N;
  logic [L-1:0] w_al, w_bl;
  logic [N-L-1:0] w_ah, w_bh;
  logic [W-1:0] w_z0, w_z1, w_z2, w_mid;
  assign w_al = i_a[L-1:0];
  assign w_ah = i_a[N-1:L];
  assign w_bl = i_b[L-1:0];
  assign w_bh = i_b[N-1:L];
  assign w_z0 = W'(w_al) * W'(w_bl);
  assign w_z2 = W'(w_ah) * W'(w_bh);
  assign w_z1 = (W'(w_al) + W'(w_ah)) * (W'(w_bl) + W'(w_bh));
  assign w_mid = w_z1 - w_z0 - w_z2;
  assign o_p = (w_z2 << (2 * L)) + (w_mid << L) + w_z0;
endmodule

// File: rtl/karatsuba_mul_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting after the last granted index
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic            i_en,
  input  logic [IDW-1:0]  i_last,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx
);
  logic w_hit;
  always_comb begin
    o_grant = '0;
    o_idx = '0;
    w_hit = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (i_en && !w_hit && i_req[(int'(i_last) + k) % NREQ]) begin
        w_hit = 1'b1;
        o_grant[(int'(i_last) + k) % NREQ] = 1'b1;
        o_idx = IDW'((int'(i_last) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/karatsuba_mul_arbiter.sv
// karatsuba_mul_arbiter: round-robin sharing of one Karatsuba multiplier with a registered tagged response
module karatsuba_mul_arbiter
  import karatsuba_mul_arbiter_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int NREQ = 4,
  parameter int IDW  = clog2_min1(NREQ),
  parameter int CW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*N-1:0]    rsp_prod,
  output logic [CW-1:0]     done_cnt
);
  logic [IDW-1:0] r_last;
  logic [IDW-1:0] w_idx;
  logic [NREQ-1:0] w_grant;
  logic w_slot_free;
  logic [N-1:0] w_a, w_b;
  logic [2*N-1:0] w_prod;
  assign w_slot_free = !rsp_valid || rsp_ready;
  assign req_ready = w_grant;
  assign w_a = req_a[w_idx*N +: N];
  assign w_b = req_b[w_idx*N +: N];
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .i_req   (req_valid),
    .i_en    (w_slot_free && !rst),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );
  Karatsuba_0 #(.N(N)) u_mul (
    .i_a (w_a),
    .i_b (w_b),
    .o_p (w_prod)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_prod <= '0;
      done_cnt <= '0;
      r_last <= IDW'(NREQ - 1);
    end else begin
      if (rsp_valid && rsp_ready) done_cnt <= done_cnt + 1'b1;
      if (w_slot_free) rsp_valid <= |w_grant;
      if (|w_grant) begin
        rsp_prod <= w_prod;
        rsp_id <= w_idx;
        r_last <= w_idx;
      end
    end
  end
  // A waiting requester must not change its operands before it is accepted.
  for (genvar i = 0; i < NREQ; i++) begin : g_chk
    a_stable: assert property (@(posedge clk) disable iff (rst)
      (req_valid[i] && !req_ready[i]) |=> (!req_valid[i] ||
      ($stable(req_a[i*N +: N]) && $stable(req_b[i*N +: N]))));
  end
endmodule
